// File: rtl/fpu_cvt_if.sv
// fpu_cvt_if -- request/response bundle for the int32 <-> float32 converter.
//   operation : 0 = signed int32 -> float32, 1 = float32 -> signed int32
//   operand   : source value
//   in_valid  : request present           in_ready  : converter idle, can accept
//   result    : converted value           out_valid : result present
//   out_ready : consumer takes the result
// master = requester/consumer side, slave = converter side.
interface fpu_cvt_if;
   logic        operation;
   logic [31:0] operand;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output operation, operand, in_valid, out_ready,
      input  in_ready, result, out_valid
   );

   modport slave (
      input  operation, operand, in_valid, out_ready,
      output in_ready, result, out_valid
   );
endinterface

// File: rtl/fpu_cvt.sv
// fpu_cvt -- iterative converter between signed int32 and IEEE-754 float32.
// One bit of normalisation / denormalisation per clock; results truncate
// toward zero, float->int saturates on overflow, Inf and NaN.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpu_cvt_if.slave (operation, operand, in_valid, in_ready,
//           result, out_valid, out_ready)
// Latency from the accept edge to out_valid is n+1 cycles, n = shift steps.
module fpu_cvt (
   input  logic     clk,
   input  logic     rst_n,
   fpu_cvt_if.slave bus
);

   localparam int         DATA_W  = 32;
   localparam logic [7:0] EXP_TOP = 8'd158;  // biased exponent of 2^31
   localparam logic [7:0] EXP_ONE = 8'd127;  // biased exponent of 2^0

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t state, state_nxt;

   logic              op_r;
   logic              sign_r;
   logic [DATA_W-1:0] mag_r;
   logic [7:0]        exp_r;
   logic [4:0]        k_r;
   logic [DATA_W-1:0] res_r;

   function automatic logic [DATA_W-1:0] pack_float(input logic s, input logic [7:0] e,
                                                    input logic [22:0] f);
      return {s, e, f};
   endfunction

   function automatic logic [DATA_W-1:0] sat_int(input logic s);
      return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
   endfunction

   function automatic logic [DATA_W-1:0] apply_sign(input logic s, input logic [DATA_W-1:0] m);
      return s ? (~m + 32'd1) : m;
   endfunction

   // Values loaded on accept, and whether the request can finish without shifting.
   logic signed [DATA_W-1:0] op_int;
   logic [7:0]               op_exp;
   logic                     acc_sign;
   logic [DATA_W-1:0]        acc_mag;
   logic [7:0]               acc_exp;
   logic [4:0]               acc_k;
   logic                     acc_direct;
   logic [DATA_W-1:0]        acc_res;

   always_comb begin
      op_int     = $signed(bus.operand);
      op_exp     = bus.operand[30:23];
      acc_sign   = bus.operand[31];
      acc_mag    = '0;
      acc_exp    = '0;
      acc_k      = '0;
      acc_direct = 1'b0;
      acc_res    = '0;
      if (!bus.operation) begin
         // -(-2^31) wraps back to 0x80000000, which is the wanted magnitude.
         acc_mag    = acc_sign ? unsigned'(-op_int) : bus.operand;
         acc_exp    = EXP_TOP;
         acc_direct = (bus.operand == '0) || acc_mag[31];
         acc_res    = (bus.operand == '0) ? '0 : pack_float(acc_sign, EXP_TOP, acc_mag[30:8]);
      end else begin
         acc_mag    = {1'b1, bus.operand[22:0], 8'h00};
         acc_exp    = op_exp;
         // 158 - e only matters for 127..157, where it equals (30 - e) mod 32.
         acc_k      = 5'd30 - op_exp[4:0];
         acc_direct = (op_exp < EXP_ONE) || (op_exp >= EXP_TOP);
         acc_res    = (op_exp < EXP_ONE) ? '0 : sat_int(acc_sign);
      end
   end

   // One shift step; step_last marks the step that completes the conversion.
   logic [DATA_W-1:0] step_mag;
   logic [7:0]        step_exp;
   logic [4:0]        step_k;
   logic              step_last;
   logic [DATA_W-1:0] step_res;

   always_comb begin
      step_mag  = mag_r;
      step_exp  = exp_r;
      step_k    = k_r;
      step_last = 1'b0;
      step_res  = '0;
      if (!op_r) begin
         step_mag  = mag_r << 1;
         step_exp  = exp_r - 8'd1;
         step_last = step_mag[31];
         step_res  = pack_float(sign_r, step_exp, step_mag[30:8]);
      end else begin
         step_mag  = mag_r >> 1;
         step_k    = k_r - 5'd1;
         step_last = (k_r == 5'd1);
         step_res  = apply_sign(sign_r, step_mag);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = acc_direct ? DONE : SHIFT;
         SHIFT:   if (step_last)    state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.result    = res_r;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= 1'b0;
         sign_r <= 1'b0;
         mag_r  <= '0;
         exp_r  <= '0;
         k_r    <= '0;
         res_r  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op_r   <= bus.operation;
               sign_r <= acc_sign;
               mag_r  <= acc_mag;
               exp_r  <= acc_exp;
               k_r    <= acc_k;
               if (acc_direct) res_r <= acc_res;
            end
            SHIFT: begin
               mag_r <= step_mag;
               exp_r <= step_exp;
               k_r   <= step_k;
               if (step_last) res_r <= step_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_cvt.sv
// tb_fpu_cvt -- scoreboard bench for fpu_cvt: the driver pushes the expected
// result and latency per request, a negedge monitor pops and compares.
module tb_fpu_cvt;

   logic clk = 1'b0;
   logic rst_n;

   fpu_cvt_if bus();

   fpu_cvt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic        bp_hold  = 1'b0;
   logic        bp_rand  = 1'b0;
   logic        mon_seen;
   logic        prev_ret;
   logic [31:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // int32 -> float32 from the value itself: find the leading power of two.
   function automatic void model_i2f(input logic [31:0] x, output logic [31:0] r, output int lat);
      longint v, m, mant;
      int     p;
      if (x == 32'd0) begin
         r = 32'd0; lat = 1; return;
      end
      v = longint'($signed(x));
      m = (v < 0) ? -v : v;
      p = 0;
      while ((longint'(1) << (p + 1)) <= m) p++;
      mant = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
      r = {x[31], 8'(127 + p), mant[22:0]};
      lat = 32 - p;
   endfunction

   // float32 -> int32 through real arithmetic with truncation.
   function automatic void model_f2i(input logic [31:0] x, output logic [31:0] r, output int lat);
      int  e, t;
      real val;
      e = int'(x[30:23]);
      if (e >= 158) begin
         r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF; lat = 1;
      end else if (e < 127) begin
         r = 32'd0; lat = 1;
      end else begin
         val = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
         t   = $rtoi(val);
         r   = x[31] ? 32'(-t) : 32'(t);
         lat = 159 - e;
      end
   endfunction

   task automatic issue(input logic op, input logic [31:0] val, input logic [31:0] r, input int lat);
      exp_t ent;
      int   n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout: in_ready=%0b, required 1", bus.in_ready);
         return;
      end
      bus.operation = op;
      bus.operand   = val;
      bus.in_valid  = 1'b1;
      ent.res = r; ent.lat = lat; ent.acc = cyc;
      sb.push_back(ent);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic issue_model(input logic op, input logic [31:0] val);
      logic [31:0] r;
      int          lat;
      if (!op) model_i2f(val, r, lat);
      else     model_f2i(val, r, lat);
      issue(op, val, r, lat);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || !bus.in_ready) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || !bus.in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: pending=%0d in_ready=%0b, required 0 and 1", sb.size(), bus.in_ready);
      end
   endtask

   // Monitor: result/latency on out_valid rise, hold checks while stalled,
   // handshake checks around retirement; also owns out_ready.
   initial begin
      mon_seen = 1'b0;
      prev_ret = 1'b0;
      bus.out_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_seen = 1'b0;
            prev_ret = 1'b0;
         end else begin
            if (prev_ret) begin
               chk("retire_out_valid", 32'(bus.out_valid), 32'd0);
               chk("retire_in_ready", 32'(bus.in_ready), 32'd1);
            end
            if (bus.out_valid) begin
               chk("done_in_ready", 32'(bus.in_ready), 32'd0);
               if (!mon_seen) begin
                  mon_seen = 1'b1;
                  held     = bus.result;
                  if (sb.size() == 0) begin
                     n_checks++; n_fail++;
                     $display("FAIL unexpected_result: got %h, required no output", bus.result);
                  end else begin
                     mon_e = sb.pop_front();
                     chk("result", bus.result, mon_e.res);
                     chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                  end
               end else begin
                  chk("hold_result", bus.result, held);
               end
            end else begin
               mon_seen = 1'b0;
            end
         end
         bus.out_ready = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
         prev_ret = rst_n && bus.out_valid && bus.out_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic        d_op  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
   logic [31:0] d_val [10] = '{32'h0000_0001, 32'hFFFF_FFFB, 32'h8000_0000, 32'h0000_0000,
                               32'h4049_0FDB, 32'hBFC0_0000, 32'h3F00_0000, 32'h4F00_0000,
                               32'hCF00_0000, 32'h7FC0_0000};
   logic [31:0] d_res [10] = '{32'h3F80_0000, 32'hC0A0_0000, 32'hCF00_0000, 32'h0000_0000,
                               32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF,
                               32'h8000_0000, 32'h7FFF_FFFF};
   int          d_lat [10] = '{32, 30, 1, 1, 31, 32, 1, 1, 1, 1};

   initial begin
      logic [31:0] v;
      logic [7:0]  e;
      logic [7:0]  e_sp [6] = '{8'd0, 8'd255, 8'd126, 8'd127, 8'd157, 8'd158};
      logic [31:0] i_sp [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      int          n;

      bus.operation = 1'b0;
      bus.operand   = '0;
      bus.in_valid  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      #1 rst_n = 1'b1;   // next rising edge is the first one out of reset

      for (int i = 0; i < 10; i++) issue(d_op[i], d_val[i], d_res[i], d_lat[i]);
      wait_drain();

      // Backpressure: stall in DONE with junk requests on the input.
      bp_hold = 1'b1;
      issue(1'b1, 32'h4F00_0000, 32'h7FFF_FFFF, 1);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_reached_done", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid  = i[0];
         bus.operation = 1'($urandom_range(0, 1));
         bus.operand   = $urandom;
      end
      @(negedge clk);
      chk("bp_still_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b0;
      bp_hold      = 1'b0;
      repeat (40) @(negedge clk);
      wait_drain();

      // Reset in the middle of a long shift sequence.
      issue(1'b0, 32'h0000_0001, 32'h3F80_0000, 32);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_result", bus.result, 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(1'b0, 32'h0000_0002, 32'h4000_0000, 31);
      wait_drain();

      // Randomised traffic with random consumer stalls.
      bp_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            if ($urandom_range(0, 7) == 0) v = i_sp[$urandom_range(0, 4)];
            else begin
               v = $urandom >> $urandom_range(0, 31);
               if ($urandom_range(0, 1) != 0) v = -v;
            end
            issue_model(1'b0, v);
         end else begin
            if ($urandom_range(0, 7) == 0) e = e_sp[$urandom_range(0, 5)];
            else e = 8'($urandom_range(120, 165));
            v = $urandom;
            v[30:23] = e;
            issue_model(1'b1, v);
         end
      end
      wait_drain();
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_cvt.md
FPU_CVT -- requirements
Module: fpu_cvt

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have: operation  input  1  0 = signed int32 to float32, 1 = float32 to signed int32.
REQ-004 SHALL have: operand  input  32  source value (two's-complement int32 or IEEE-754 float32).
REQ-005 SHALL have: in_valid  input  1  operand/operation valid.
REQ-006 SHALL have: in_ready  output  1  block can accept a request.
REQ-007 SHALL have: result  output  32  converted value.
REQ-008 SHALL have: out_valid  output  1  result valid.
REQ-009 SHALL have: out_ready  input  1  consumer accepts result.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-011 SHALL accept a request on a rising edge with in_valid=1 in IDLE, latching operation and operand.
REQ-012 SHALL, on accept, hold a 32-bit magnitude register, sign bit, 8-bit exponent and 5-bit shift counter k.
REQ-013 i2f accept: sign = operand[31]; mag = abs(operand), unsigned, so 0x80000000 stays 0x80000000; exp = 158.
REQ-014 i2f zero operand: go directly to DONE with result 0x00000000.
REQ-015 i2f SHIFT: each cycle while mag[31]=0: shift mag left 1 and decrement exp by 1; leave SHIFT when mag[31]=1.
REQ-016 i2f result: {sign, exp, mag[30:8]}; truncate toward zero, no rounding.
REQ-017 f2i accept: e = operand[30:23]; mag = {1, operand[22:0], 8'b0}; k = 158 - e.
REQ-018 f2i e < 127, including zero and denormals: go directly to DONE with result 0x00000000.
REQ-019 f2i e >= 158, including Inf and NaN: go directly to DONE with saturated result: 0x7FFFFFFF if sign=0, 0x80000000 if sign=1.
REQ-020 f2i 127 <= e <= 157: SHIFT shifts mag right 1 per cycle and decrements k, for exactly k cycles.
REQ-021 f2i result: mag when sign=0, two's complement of mag when sign=1; fractional bits truncated toward zero.
REQ-022 Latency: out_valid SHALL rise n+1 cycles after the accept edge, where n = number of SHIFT cycles (0..31); max 32 cycles.
REQ-023 In DONE, out_valid = 1 and result SHALL hold stable until a rising edge with out_ready=1; the block then returns to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; no request is queued.
REQ-025 A new request SHALL NOT be accepted on the same edge that retires a result; the earliest next accept is one cycle later.
REQ-026 result SHALL be don't-care while out_valid=0.

Reset
REQ-027 While rst_n=0: state = IDLE, in_ready = 1, out_valid = 0, result = 0x00000000, internal registers cleared.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL abort the conversion immediately; no result is produced after release.
REQ-029 First accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-030 i2f 0x00000001 -> result 0x3F800000, 31 SHIFT cycles, out_valid 32 cycles after accept; i2f 0xFFFFFFFB (-5) -> 0xC0A00000.
REQ-031 i2f 0x80000000 -> 0xCF000000 with 0 SHIFT cycles, out_valid 1 cycle after accept; i2f 0 -> 0x00000000.
REQ-032 f2i 0x40490FDB (3.14159) -> 0x00000003 after 30 SHIFT cycles; f2i 0xBFC00000 (-1.5) -> 0xFFFFFFFF; f2i 0x3F000000 (0.5) -> 0.
REQ-033 f2i 0x4F000000 -> 0x7FFFFFFF; 0xCF000000 -> 0x80000000; 0x7FC00000 (NaN) -> 0x7FFFFFFF; each with 1-cycle latency.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> retires, in_ready=1 on the next cycle.
REQ-035 Assert rst_n=0 during SHIFT of i2f 1 -> outputs immediately at reset values; after release, i2f 0x00000002 -> 0x40000000 with correct 31-cycle latency.
